// File: rtl/r_ptr_empty.sv
// rtl/r_ptr_empty.sv - FIFO read pointer, write-pointer sync, empty/level/underflow (optional R_ALMOST_EMPTY_EN)
module r_ptr_empty #(
    parameter int ADDR_WIDTH = 5
`ifdef R_ALMOST_EMPTY_EN
    ,
    parameter int AE_THRESH = 4
`endif
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   g_wptr,
    output logic [ADDR_WIDTH:0]   b_rptr,
    output logic [ADDR_WIDTH:0]   g_rptr,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  underflow
`ifdef R_ALMOST_EMPTY_EN
    ,
    output logic                  almost_empty
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wq1;
    logic [PW-1:0] wq2;
    logic [PW-1:0] b_wsync;
    logic [PW-1:0] b_next;
    logic [PW-1:0] g_next;
    logic [PW-1:0] level_next;
    logic          rd;

    // Each binary bit is the parity of all Gray bits at or above it.
    always_comb begin
        b_wsync = '0;
        for (int i = 0; i < PW; i++) begin
            b_wsync[i] = ^(wq2 >> i);
        end
    end

    assign rd         = r_en & ~empty;
    assign b_next     = b_rptr + {{ADDR_WIDTH{1'b0}}, rd};
    assign g_next     = b_next ^ (b_next >> 1);
    assign level_next = b_wsync - b_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            wq1       <= '0;
            wq2       <= '0;
            b_rptr    <= '0;
            g_rptr    <= '0;
            empty     <= 1'b1;
            rlevel    <= '0;
            underflow <= 1'b0;
        end else begin
            wq1       <= g_wptr;
            wq2       <= wq1;
            b_rptr    <= b_next;
            g_rptr    <= g_next;
            // Compare against the older wq2 so a stale write pointer can only keep us empty.
            empty     <= (g_next == wq2);
            rlevel    <= level_next;
            underflow <= r_en & empty;
        end
    end

`ifdef R_ALMOST_EMPTY_EN
    localparam logic [PW-1:0] AE_T = AE_THRESH[PW-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (level_next <= AE_T);
        end
    end
`endif

endmodule

// File: tb/tb_r_ptr_empty.sv
// tb/tb_r_ptr_empty.sv - self-checking bench for r_ptr_empty
module tb_r_ptr_empty;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       r_en = 1'b0;
    logic [5:0] g_wptr;
    logic [5:0] b_rptr;
    logic [5:0] g_rptr;
    logic       empty;
    logic [5:0] rlevel;
    logic       underflow;
`ifdef R_ALMOST_EMPTY_EN
    logic       almost_empty;
`endif

    int wb = 5;
    int errors = 0;
    int checks = 0;

    always #5 rclk = ~rclk;

    function automatic logic [5:0] gray(input int v);
        logic [5:0] b;
        b = v[5:0];
        return b ^ (b >> 1);
    endfunction

    assign g_wptr = gray(wb);

    r_ptr_empty dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .r_en      (r_en),
        .g_wptr    (g_wptr),
        .b_rptr    (b_rptr),
        .g_rptr    (g_rptr),
        .empty     (empty),
        .rlevel    (rlevel),
        .underflow (underflow)
`ifdef R_ALMOST_EMPTY_EN
        ,
        .almost_empty (almost_empty)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: read count and the write count as it appears after two sync stages.
    int   m_rc = 0;
    int   m_ws1 = 0;
    int   m_ws2 = 0;
    int   m_level = 0;
    logic m_empty = 1'b1;
    logic m_uf = 1'b0;
    logic m_ae = 1'b1;
    logic m_valid = 1'b0;
    logic m_rst = 1'b0;

    always @(posedge rclk) begin
        if (rrst) begin
            m_rc = 0; m_ws1 = 0; m_ws2 = 0; m_level = 0;
            m_empty = 1'b1; m_uf = 1'b0; m_ae = 1'b1;
            m_valid = 1'b1; m_rst = 1'b1;
        end else begin
            m_rst = 1'b0;
            m_uf = r_en && m_empty;
            if (r_en && !m_empty) m_rc = (m_rc + 1) % 64;
            m_level = (m_ws2 - m_rc + 64) % 64;
            m_empty = (m_level == 0);
            m_ae = (m_level <= 4);
            m_ws2 = m_ws1;
            m_ws1 = wb % 64;
        end
    end

    logic [5:0] prev_g;
    logic       prev_ok = 1'b0;

    always @(negedge rclk) begin
        if (m_valid) begin
            check("b_rptr", b_rptr, m_rc);
            check("g_rptr", g_rptr, gray(m_rc));
            check("empty", empty, m_empty);
            check("rlevel", rlevel, m_level);
            check("underflow", underflow, m_uf);
`ifdef R_ALMOST_EMPTY_EN
            check("almost_empty", almost_empty, m_ae);
`endif
            if (prev_ok && !m_rst) check("g_rptr_step", $countones(g_rptr ^ prev_g) <= 1, 1);
            prev_g  = g_rptr;
            prev_ok = 1'b1;
        end
    end

    task automatic tick(input logic en, input int w, input logic rst);
        r_en = en;
        wb   = w;
        rrst = rst;
        @(negedge rclk);
    endtask

    initial begin
        // Reset with a nonzero write pointer
        tick(0, 5, 1);
        tick(0, 5, 1);
        check("rst_b_rptr", b_rptr, 0);
        check("rst_g_rptr", g_rptr, 0);
        check("rst_empty", empty, 1);
        check("rst_rlevel", rlevel, 0);
        check("rst_underflow", underflow, 0);
        tick(0, 5, 0);
        tick(0, 5, 0);
        check("rel_empty_e2", empty, 1);
        tick(0, 5, 0);
        check("rel_empty_e3", empty, 0);
        check("rel_rlevel_e3", rlevel, 5);

        // Read while empty
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0);
            check("uf_pulse", underflow, 1);
            check("uf_b_rptr", b_rptr, 0);
            check("uf_empty", empty, 1);
        end
        tick(0, 0, 0);
        check("uf_drop", underflow, 0);

        // Basic drain of three entries
        tick(0, 3, 0);
        tick(0, 3, 0);
        check("drain_empty_e2", empty, 1);
        tick(0, 3, 0);
        check("drain_empty_e3", empty, 0);
        check("drain_level", rlevel, 3);
        for (int i = 1; i <= 3; i++) begin
            tick(1, 3, 0);
            check("drain_b_rptr", b_rptr, i);
            check("drain_rlevel", rlevel, 3 - i);
        end
        check("drain_g_rptr", g_rptr, 6'b000010);
        check("drain_last_empty", empty, 1);
        tick(1, 3, 0);
        check("drain_uf", underflow, 1);
        check("drain_hold", b_rptr, 3);

        // Full drain and pointer wrap
        tick(0, 32, 1);
        tick(0, 32, 0);
        tick(0, 32, 0);
        tick(0, 32, 0);
        check("full_level", rlevel, 32);
        for (int i = 0; i < 32; i++) tick(1, 32, 0);
        check("full_b_rptr", b_rptr, 6'b100000);
        check("full_g_rptr", g_rptr, 6'b110000);
        check("full_empty", empty, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("wrap_level", rlevel, 32);
        for (int i = 0; i < 31; i++) tick(1, 0, 0);
        check("wrap_b63", b_rptr, 63);
        check("wrap_g63", g_rptr, 6'b100000);
        tick(1, 0, 0);
        check("wrap_b0", b_rptr, 0);
        check("wrap_g0", g_rptr, 0);
        check("wrap_empty", empty, 1);

        // Mid-operation reset
        tick(0, 10, 0);
        tick(0, 10, 0);
        tick(0, 10, 0);
        for (int i = 0; i < 5; i++) tick(1, 10, 0);
        check("mid_level5", rlevel, 5);
        tick(1, 10, 1);
        check("mid_b_rptr", b_rptr, 0);
        check("mid_empty", empty, 1);
        check("mid_rlevel", rlevel, 0);
        tick(0, 10, 0);
        tick(0, 10, 0);
        check("mid_empty_e2", empty, 1);
        tick(0, 10, 0);
        check("mid_rlevel_e3", rlevel, 10);

`ifdef R_ALMOST_EMPTY_EN
        tick(0, 6, 1);
        tick(0, 6, 0);
        tick(0, 6, 0);
        tick(0, 6, 0);
        check("ae_lvl6", almost_empty, 0);
        for (int i = 5; i >= 0; i--) begin
            tick(1, 6, 0);
            check("ae_level", rlevel, i);
            check("ae_flag", almost_empty, (i <= 4));
        end
`endif

        // Concurrent writes and reads, write side never overruns
        for (int i = 0; i < 80; i++) begin
            int nw;
            nw = wb;
            if (((wb - m_rc + 64) % 64) < 30 && $urandom_range(0, 1) == 1) nw = (wb + 1) % 64;
            tick(1'($urandom_range(0, 1)), nw, 0);
        end
        for (int i = 0; i < 40; i++) tick(1, wb, 0);
        check("final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
